// File: rtl/fixed_leaky_relu_seq.sv
// -----------------------------------------------------------------------------
// fixed_leaky_relu_seq
//
// Streaming fixed-point LeakyReLU with a runtime-programmable negative slope.
// A beat of P lanes is captured in IDLE. It is then evaluated NUM_MULT lanes
// per cycle in COMPUTE, using G = P/NUM_MULT cycles. The result is held in
// OUTPUT until the consumer takes it.
//
// Slope modes (latched from the cfg_* port while IDLE):
//   cfg_mode = 0 : negative lanes become x >>> cfg_shift (power-of-2 slope)
//   cfg_mode = 1 : negative lanes become (x * cfg_slope) >>> SLOPE_WIDTH,
//                  where cfg_slope is an unsigned all-fractional value
// Results are cast to the output fractional precision and saturated.
//
// Optional feature macro: FIXED_LEAKY_RELU_ROUND_EN
//   defined   : every right shift rounds half-up
//   undefined : every right shift floors
//
// Ports:
//   clk, rst (async, active-low)
//   cfg_mode, cfg_shift, cfg_slope, cfg_valid / cfg_ready : slope config
//   data_in_0 [P lanes], data_in_0_valid / data_in_0_ready  : input stream
//   data_out_0 [P lanes], data_out_0_valid / data_out_0_ready : output stream
// -----------------------------------------------------------------------------
module fixed_leaky_relu_seq #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 4,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int NUM_MULT                    = 2,
  parameter int SLOPE_WIDTH                 = 8,
  parameter int SHIFT_WIDTH                 = 4,
  parameter int RESET_SHIFT                 = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic                   cfg_mode,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic [SLOPE_WIDTH-1:0] cfg_slope,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0]
               [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                               data_in_0_valid,
  output logic                               data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0]
               [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                               data_out_0_valid,
  input  logic                               data_out_0_ready
);

  localparam int P        = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int G        = P / NUM_MULT;
  localparam int GW       = (G > 1) ? $clog2(G) : 1;
  localparam int IN_W     = DATA_IN_0_PRECISION_0;
  localparam int IN_FRAC  = DATA_IN_0_PRECISION_1;
  localparam int OUT_W    = DATA_OUT_0_PRECISION_0;
  localparam int OUT_FRAC = DATA_OUT_0_PRECISION_1;
  localparam int UP       = (OUT_FRAC >= IN_FRAC) ? OUT_FRAC - IN_FRAC : 0;
  localparam int DN       = (IN_FRAC > OUT_FRAC) ? IN_FRAC - OUT_FRAC : 0;
  // Working width holds the full slope product, the output up-shift and a
  // rounding bias without overflow.
  localparam int CW0      = IN_W + SLOPE_WIDTH + UP + 2;
  localparam int CW       = (CW0 > OUT_W) ? CW0 : OUT_W + 1;
  // Any power-of-2 shift beyond IN_W+1 gives the same result as IN_W+1
  // (floor: -1, round: 0), so the shift is clamped there to keep the
  // rounding bias inside CW.
  localparam int SMAX     = IN_W + 1;

  localparam logic signed [CW-1:0] OMAX = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] OMIN = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

  state_t                   state, state_nxt;
  logic                     mode_r;
  logic [SHIFT_WIDTH-1:0]   shift_r;
  logic [SLOPE_WIDTH-1:0]   slope_r;
  logic [7:0]               sh_eff;
  logic                     in_hs;
  logic                     last_grp;

  logic [P-1:0][IN_W-1:0]   x_p0;
  logic [GW-1:0]            grp_p0;
  logic [P-1:0][OUT_W-1:0]  y_p1;

  logic signed [IN_W-1:0]   lane_x [NUM_MULT];
  logic signed [OUT_W-1:0]  lane_y [NUM_MULT];

  // Arithmetic right shift, floor or round-half-up depending on build.
  function automatic logic signed [CW-1:0] shr_rnd(input logic signed [CW-1:0] v,
                                                   input logic [7:0] s);
    logic signed [CW-1:0] t;
    t = v;
`ifdef FIXED_LEAKY_RELU_ROUND_EN
    if (s != 8'd0) t = v + $signed(CW'(1) << (s - 8'd1));
`endif
    return t >>> s;
  endfunction

  // Clamp to the signed output range.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [CW-1:0] v);
    logic signed [CW-1:0] t;
    t = v;
    if (v > OMAX) t = OMAX;
    if (v < OMIN) t = OMIN;
    return t[OUT_W-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] leaky(input logic signed [IN_W-1:0] x,
                                                    input logic mode,
                                                    input logic [7:0] sh,
                                                    input logic [SLOPE_WIDTH-1:0] slope);
    logic signed [CW-1:0] xw, sl, y;
    xw = CW'(x);
    sl = CW'($signed({1'b0, slope}));
    if (!x[IN_W-1])  y = xw;
    else if (!mode)  y = shr_rnd(xw, sh);
    else             y = shr_rnd(xw * sl, 8'(SLOPE_WIDTH));
    y = y <<< UP;
    y = shr_rnd(y, 8'(DN));
    return sat_out(y);
  endfunction

  assign in_hs    = data_in_0_valid && data_in_0_ready;
  assign last_grp = (grp_p0 == GW'(G - 1));
  // SHIFT_WIDTH is assumed to be at most 8 bits.
  assign sh_eff   = (8'(shift_r) > 8'(SMAX)) ? 8'(SMAX) : 8'(shift_r);

  always_comb begin
    state_nxt        = state;
    cfg_ready        = 1'b0;
    data_in_0_ready  = 1'b0;
    data_out_0_valid = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready       = 1'b1;
        // Configuration wins a same-cycle tie with data.
        data_in_0_ready = !cfg_valid;
        if (data_in_0_valid && !cfg_valid) state_nxt = COMPUTE;
      end
      COMPUTE: if (last_grp) state_nxt = OUTPUT;
      OUTPUT: begin
        data_out_0_valid = 1'b1;
        if (data_out_0_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign data_out_0 = y_p1;

  // Stage p0: beat capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (in_hs) x_p0 <= data_in_0;
  end

  // Select the lanes of the current group for the shared lane units.
  always_comb begin
    for (int j = 0; j < NUM_MULT; j++) lane_x[j] = '0;
    for (int g = 0; g < G; g++)
      for (int j = 0; j < NUM_MULT; j++)
        if (grp_p0 == GW'(g)) lane_x[j] = x_p0[g*NUM_MULT+j];
    for (int j = 0; j < NUM_MULT; j++)
      lane_y[j] = leaky(lane_x[j], mode_r, sh_eff, slope_r);
  end

  // Stage p1: group-by-group result register, control and configuration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      grp_p0  <= '0;
      mode_r  <= 1'b0;
      shift_r <= SHIFT_WIDTH'(RESET_SHIFT);
      slope_r <= '0;
      y_p1    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cfg_valid) begin
        mode_r  <= cfg_mode;
        shift_r <= cfg_shift;
        slope_r <= cfg_slope;
      end
      if (state == COMPUTE) begin
        grp_p0 <= last_grp ? '0 : grp_p0 + GW'(1);
        for (int g = 0; g < G; g++)
          for (int j = 0; j < NUM_MULT; j++)
            if (grp_p0 == GW'(g)) y_p1[g*NUM_MULT+j] <= lane_y[j];
      end
    end
  end

endmodule
